// File: rtl/pair_eq_pkg.sv
// Shared definitions for the pair equality checker: the reduction mode
// enum and the width rule for the first-error channel index.
package pair_eq_pkg;

    // Reduction applied to the per-pair equality vector in stage 2.
    typedef enum logic {
        MODE_XNOR = 1'b0,  // XNOR-reduce of eq_vec (legacy two-pair behaviour)
        MODE_AND  = 1'b1   // all pairs equal
    } mode_e;

    // Width of the first_err_ch index: clog2(ch), never narrower than 1 bit.
    function automatic int first_err_w(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

endpackage

// File: rtl/pair_eq_lane.sv
// One compare lane: a W-bit equality test registered into stage 1.
// The lane register loads on every clock; qualification is carried by the
// single stage-1 valid bit kept in the top level.
module pair_eq_lane #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         eq_o
);

    logic eq_d;
    logic eq_q;

    // Combinational equality of the two operands of this pair.
    always_comb begin
        eq_d = (a_i == b_i);
    end

    // Stage-1 register for this lane's equality bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eq_q <= 1'b0;
        end else begin
            eq_q <= eq_d;
        end
    end

    assign eq_o = eq_q;

endmodule

// File: rtl/pair_eq_checker.sv
// Two-stage pipelined equality checker over CH operand pairs.
//
// Optional statistics (err_cnt, err_flag, first_err_ch, clr) are compiled in
// by defining PAIR_EQ_CHECKER_STATS_EN; otherwise those outputs read 0 and
// clr has no effect.
//
// Valid semantics: in_valid qualifies a/b in the cycle it is high; there is
// no ready, every qualified input is accepted. out_valid is high for exactly
// one cycle per accepted input, two cycles after it was presented. While
// out_valid is low, out and eq_vec hold the last valid result.
//
// A mismatch event is a cycle with out_valid=1 and eq_vec not all ones. The
// statistics registers absorb that event on the clock edge that ends the
// cycle, so they show it one cycle after out_valid.
module pair_eq_checker
    import pair_eq_pkg::*;
#(
    parameter int    W     = 3,
    parameter int    CH    = 2,
    parameter mode_e MODE  = MODE_XNOR,
    parameter int    CNT_W = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [CH*W-1:0]           a,
    input  logic [CH*W-1:0]           b,
    input  logic                      clr,
    output logic                      out_valid,
    output logic                      out,
    output logic [CH-1:0]             eq_vec,
    output logic [CNT_W-1:0]          err_cnt,
    output logic                      err_flag,
    output logic [first_err_w(CH)-1:0] first_err_ch
);

    localparam int FW = first_err_w(CH);

    // ------------------------------------------------------------------
    // Stage 1: per-lane equality registers plus one shared valid bit.
    // ------------------------------------------------------------------
    logic [CH-1:0] s1_eq;
    logic          s1_valid_d;
    logic          s1_valid_q;

    for (genvar g = 0; g < CH; g++) begin : g_lane
        pair_eq_lane #(
            .W (W)
        ) u_lane (
            .clk  (clk),
            .rst  (rst),
            .a_i  (a[g*W +: W]),
            .b_i  (b[g*W +: W]),
            .eq_o (s1_eq[g])
        );
    end

    // Stage-1 valid simply mirrors in_valid one clock later.
    always_comb begin
        s1_valid_d = in_valid;
    end

    // Stage-1 valid register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: reduction and result hold.
    // ------------------------------------------------------------------
    logic          reduced;
    logic          out_valid_d;
    logic          out_valid_q;
    logic          out_d;
    logic          out_q;
    logic [CH-1:0] eq_vec_d;
    logic [CH-1:0] eq_vec_q;

    // Reduce the stage-1 vector; result and vector only move on a valid
    // stage-1 entry so idle cycles keep the last result visible.
    always_comb begin
        if (MODE == MODE_AND) begin
            reduced = &s1_eq;
        end else begin
            reduced = ~^s1_eq;
        end
        out_valid_d = s1_valid_q;
        out_d       = out_q;
        eq_vec_d    = eq_vec_q;
        if (s1_valid_q) begin
            out_d    = reduced;
            eq_vec_d = s1_eq;
        end
    end

    // Stage-2 result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_q       <= 1'b0;
            eq_vec_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            eq_vec_q    <= eq_vec_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign eq_vec    = eq_vec_q;

    // ------------------------------------------------------------------
    // Statistics on stage-2 results.
    // ------------------------------------------------------------------
`ifdef PAIR_EQ_CHECKER_STATS_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             mismatch_ev;
    logic [FW-1:0]    low_zero;
    logic [CNT_W-1:0] err_cnt_d;
    logic [CNT_W-1:0] err_cnt_q;
    logic             err_flag_d;
    logic             err_flag_q;
    logic [FW-1:0]    first_err_d;
    logic [FW-1:0]    first_err_q;

    // Event detect and lowest failing pair; scanning downward leaves the
    // smallest index with a zero equality bit.
    always_comb begin
        mismatch_ev = out_valid_q & ~(&eq_vec_q);
        low_zero    = '0;
        for (int i = CH - 1; i >= 0; i--) begin
            if (!eq_vec_q[i]) begin
                low_zero = FW'(i);
            end
        end
    end

    // Next-state for the statistics: clr beats a coincident event; the
    // counter saturates; the index is captured only by the flag-setting event.
    always_comb begin
        err_cnt_d   = err_cnt_q;
        err_flag_d  = err_flag_q;
        first_err_d = first_err_q;
        if (clr) begin
            err_cnt_d   = '0;
            err_flag_d  = 1'b0;
            first_err_d = '0;
        end else if (mismatch_ev) begin
            if (err_cnt_q != {CNT_W{1'b1}}) begin
                err_cnt_d = err_cnt_q + CNT_ONE;
            end
            if (!err_flag_q) begin
                err_flag_d  = 1'b1;
                first_err_d = low_zero;
            end
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q   <= '0;
            err_flag_q  <= 1'b0;
            first_err_q <= '0;
        end else begin
            err_cnt_q   <= err_cnt_d;
            err_flag_q  <= err_flag_d;
            first_err_q <= first_err_d;
        end
    end

    assign err_cnt      = err_cnt_q;
    assign err_flag     = err_flag_q;
    assign first_err_ch = first_err_q;
`else
    // Statistics absent: outputs read as zero and clr is not used.
    logic stats_unused;
    assign stats_unused = clr;

    assign err_cnt      = '0;
    assign err_flag     = 1'b0;
    assign first_err_ch = '0;
`endif

endmodule

// File: tb/tb_pair_eq_checker.sv
// Self-checking bench for pair_eq_checker: a vector table, hand-written
// multi-cycle sequences and a long randomized run against a reference model.
module tb_pair_eq_checker;
    import pair_eq_pkg::*;

    localparam int W  = 3;
    localparam int CH = 2;
    localparam int N  = W * CH;
    localparam int FW = first_err_w(CH);
`ifdef PAIR_EQ_CHECKER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    // ---------------- clock / reset / stimulus signals ----------------
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         clr = 1'b0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;

    always #5 clk = ~clk;

    logic          ov_x, out_x, flag_x;
    logic          ov_a, out_a, flag_a;
    logic          ov_s, out_s, flag_s;
    logic [CH-1:0] eq_x, eq_a, eq_s;
    logic [15:0]   cnt_x, cnt_a;
    logic [1:0]    cnt_s;
    logic [FW-1:0] first_x, first_a, first_s;

    pair_eq_checker #(.W(W), .CH(CH), .MODE(MODE_XNOR), .CNT_W(16)) dut_x (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .clr(clr),
        .out_valid(ov_x), .out(out_x), .eq_vec(eq_x), .err_cnt(cnt_x),
        .err_flag(flag_x), .first_err_ch(first_x));

    pair_eq_checker #(.W(W), .CH(CH), .MODE(MODE_AND), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .clr(clr),
        .out_valid(ov_a), .out(out_a), .eq_vec(eq_a), .err_cnt(cnt_a),
        .err_flag(flag_a), .first_err_ch(first_a));

    pair_eq_checker #(.W(W), .CH(CH), .MODE(MODE_XNOR), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .clr(clr),
        .out_valid(ov_s), .out(out_s), .eq_vec(eq_s), .err_cnt(cnt_s),
        .err_flag(flag_s), .first_err_ch(first_s));

    // ---------------- reference model ----------------
    typedef struct {
        logic [CH-1:0] eq;
        logic          ox;
        logic          oa;
        int            due;
    } res_t;

    res_t          exp_q[$];
    int            cyc = 0;
    logic          exp_ov = 1'b0;
    logic [CH-1:0] h_eq = '0;
    logic          h_ox = 1'b0;
    logic          h_oa = 1'b0;
    logic          pend_ev = 1'b0;
    int            pend_first = 0;
    int            m_cnt = 0;
    int            m_cnt_s = 0;
    logic          m_flag = 1'b0;
    int            m_first = 0;

    int n_chk = 0;
    int n_pass = 0;

    // Result of one input from the rules: pair equality, parity of equal
    // pairs (XNOR reduce is 1 for an even count) and "all pairs equal".
    function automatic res_t ref_model(input logic [N-1:0] av, input logic [N-1:0] bv);
        res_t r;
        int   neq = 0;
        for (int i = 0; i < CH; i++) begin
            r.eq[i] = ((int'(av) >> (i * W)) % (1 << W)) == ((int'(bv) >> (i * W)) % (1 << W));
            if (r.eq[i]) neq++;
        end
        r.ox  = (neq % 2) == 0;
        r.oa  = (neq == CH);
        r.due = 0;
        return r;
    endfunction

    function automatic int lowest_zero(input logic [CH-1:0] v);
        int k = -1;
        for (int i = 0; i < CH; i++) if (!v[i] && k < 0) k = i;
        return k;
    endfunction

    function automatic logic [N-1:0] rbits();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = ($urandom_range(15) < 6);
        return r;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic check_all();
        chk("ov_x",    ov_x,  exp_ov);
        chk("out_x",   out_x, h_ox);
        chk("eq_x",    eq_x,  h_eq);
        chk("ov_a",    ov_a,  exp_ov);
        chk("out_a",   out_a, h_oa);
        chk("eq_a",    eq_a,  h_eq);
        chk("ov_s",    ov_s,  exp_ov);
        chk("out_s",   out_s, h_ox);
        chk("cnt_x",   cnt_x,   STATS ? m_cnt   : 0);
        chk("flag_x",  flag_x,  STATS ? m_flag  : 0);
        chk("first_x", first_x, STATS ? m_first : 0);
        chk("cnt_s",   cnt_s,   STATS ? m_cnt_s : 0);
        chk("flag_a",  flag_a,  STATS ? m_flag  : 0);
    endtask

    // One clock: inputs are already set (at a negedge); the model absorbs the
    // rising edge, then outputs are compared on the following falling edge.
    task automatic cycle();
        res_t r;
        @(posedge clk);
        cyc++;
        if (clr) begin
            m_cnt = 0; m_cnt_s = 0; m_flag = 1'b0; m_first = 0;
        end else if (pend_ev) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt_s < 3) m_cnt_s++;
            if (!m_flag) begin
                m_flag  = 1'b1;
                m_first = pend_first;
            end
        end
        if (in_valid) begin
            r = ref_model(a, b);
            r.due = cyc + 1;
            exp_q.push_back(r);
        end
        exp_ov = 1'b0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            r = exp_q.pop_front();
            exp_ov = 1'b1;
            h_eq = r.eq;
            h_ox = r.ox;
            h_oa = r.oa;
        end
        pend_ev    = exp_ov && (h_eq != {CH{1'b1}});
        pend_first = lowest_zero(h_eq);
        @(negedge clk);
        check_all();
    endtask

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        exp_q.delete();
        exp_ov = 1'b0; h_eq = '0; h_ox = 1'b0; h_oa = 1'b0;
        pend_ev = 1'b0; pend_first = 0;
        m_cnt = 0; m_cnt_s = 0; m_flag = 1'b0; m_first = 0;
        check_all();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [N-1:0]  a;
        logic [N-1:0]  b;
        logic [CH-1:0] eq;
        logic          ox;
        logic          oa;
    } vec_t;

    vec_t tbl[8];

    initial begin
        // pair 1 is the upper octal digit, pair 0 the lower
        tbl[0] = '{6'o52, 6'o52, 2'b11, 1'b1, 1'b1};
        tbl[1] = '{6'o52, 6'o42, 2'b01, 1'b0, 1'b0};
        tbl[2] = '{6'o52, 6'o53, 2'b10, 1'b0, 1'b0};
        tbl[3] = '{6'o52, 6'o43, 2'b00, 1'b1, 1'b0};
        tbl[4] = '{6'o00, 6'o00, 2'b11, 1'b1, 1'b1};
        tbl[5] = '{6'o77, 6'o70, 2'b10, 1'b0, 1'b0};
        tbl[6] = '{6'o07, 6'o70, 2'b00, 1'b1, 1'b0};
        tbl[7] = '{6'o34, 6'o34, 2'b11, 1'b1, 1'b1};

        #2;
        do_reset();

        // Table: one vector, then the result two cycles later.
        for (int i = 0; i < 8; i++) begin
            a = tbl[i].a; b = tbl[i].b; in_valid = 1'b1;
            cycle();
            in_valid = 1'b0;
            cycle();
            chk("tbl_ov",  ov_x,  1'b1);
            chk("tbl_eq",  eq_x,  tbl[i].eq);
            chk("tbl_ox",  out_x, tbl[i].ox);
            chk("tbl_oa",  out_a, tbl[i].oa);
        end
        // Five mismatching vectors seen; first failure was pair 1 (vector 1)
        // and the later pair-0 failure must not move it.
        chk("tbl_cnt",   cnt_x,   STATS ? 5 : 0);
        chk("tbl_cnt_s", cnt_s,   STATS ? 3 : 0);
        chk("tbl_flag",  flag_x,  STATS ? 1 : 0);
        chk("tbl_first", first_x, STATS ? 1 : 0);

        // Saturation and clr coincident with the fifth event.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            a = 6'o52; b = 6'o43; in_valid = 1'b1;
            cycle();
        end
        in_valid = 1'b0;
        cycle();
        chk("sat_ov5", ov_s,  1'b1);
        chk("sat_cnt", cnt_s, STATS ? 3 : 0);
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        chk("clr_cnt_s", cnt_s,  0);
        chk("clr_cnt",   cnt_x,  0);
        chk("clr_flag",  flag_x, 0);
        cycle();

        // Reset with results in flight, then first-result latency.
        a = 6'o11; b = 6'o12; in_valid = 1'b1;
        cycle();
        a = 6'o33; b = 6'o33;
        cycle();
        in_valid = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("rst_no_ov", ov_x, 1'b0);
        end
        a = 6'o25; b = 6'o25; in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        chk("lat_ov_c1", ov_x, 1'b0);
        cycle();
        chk("lat_ov_c2", ov_x, 1'b1);
        chk("lat_eq",    eq_x, 2'b11);
        cycle();
        chk("lat_ov_c3", ov_x, 1'b0);

        // Randomized run against the model.
        for (int i = 0; i < 20000; i++) begin
            in_valid = ($urandom_range(3) != 0);
            a   = rbits();
            b   = rbits();
            clr = ($urandom_range(63) == 0);
            cycle();
        end
        in_valid = 1'b0;
        clr = 1'b0;
        for (int i = 0; i < 3; i++) cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pair_eq_checker.md
PAIR_EQ_CHECKER -- requirements
Module: pair_eq_checker

Interface
REQ-001 The block SHALL have parameter W, default 3, bit width of each compared operand.
REQ-002 The block SHALL have parameter CH, default 2 (range 1..16), number of compared pairs.
REQ-003 The block SHALL have parameter MODE, default MODE_XNOR: MODE_XNOR = XNOR-reduce of per-pair equality; MODE_AND = all pairs equal.
REQ-004 The block SHALL have parameter CNT_W, default 16, mismatch counter width.
REQ-005 The block SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-006 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 The block SHALL have port in_valid, input, 1, qualifies a and b this cycle.
REQ-008 The block SHALL have port a, input, CH*W, operand A; pair i at bits [i*W +: W].
REQ-009 The block SHALL have port b, input, CH*W, operand B; same packing.
REQ-010 The block SHALL have port clr, input, 1, synchronous clear of statistics.
REQ-011 The block SHALL have port out_valid, output, 1, out and eq_vec are valid.
REQ-012 The block SHALL have port out, output, 1, reduced compare result.
REQ-013 The block SHALL have port eq_vec, output, CH, per-pair equality, bit i = (a_i == b_i).
REQ-014 The block SHALL have ports err_cnt (output, CNT_W), err_flag (output, 1) and first_err_ch (output, clog2(CH) min 1).

Function
REQ-015 Stage 1 SHALL register eq_vec and a valid bit on every clock; the stage-1 valid bit equals in_valid.
REQ-016 Stage 2 SHALL register out = ~^eq_vec (MODE_XNOR) or &eq_vec (MODE_AND) together with out_valid.
REQ-017 Latency SHALL be exactly 2 cycles from in_valid to out_valid; one result per cycle, no backpressure.
REQ-018 When out_valid is 0, out and eq_vec SHALL hold their last valid values.
REQ-019 With CH=2, MODE_XNOR, out SHALL equal ((a0==b0)==(a1==b1)), the legacy two-pair behaviour.
REQ-020 A mismatch event SHALL be a stage-2 result with out_valid=1 and eq_vec not all ones.
REQ-021 Each mismatch event SHALL increment err_cnt by 1; err_cnt saturates at 2^CNT_W-1, with no wrap.
REQ-022 err_flag SHALL be sticky: it is set on the first mismatch event and held until clr or rst.
REQ-023 first_err_ch SHALL capture the lowest index i with eq_vec[i]=0 on the event that sets err_flag only.
REQ-024 clr and a mismatch in the same cycle SHALL clear: clr wins; the event is not counted.
REQ-025 In-flight pipeline data SHALL be unaffected by clr.
REQ-026 X or Z on a or b SHALL NOT be filtered; the bench drives known values only.

Reset
REQ-027 rst SHALL asynchronously force out_valid=0, out=0, eq_vec=0, err_cnt=0, err_flag=0, first_err_ch=0, and both stage valids to 0.
REQ-028 Reset mid-operation SHALL drop all in-flight results; no out_valid pulse is generated for them after release.
REQ-029 The first in_valid sampled after rst deassertion SHALL produce out_valid 2 cycles later.

Configuration
REQ-030 Macro PAIR_EQ_CHECKER_STATS_EN SHALL compile in err_cnt, err_flag and first_err_ch logic.
REQ-031 Without PAIR_EQ_CHECKER_STATS_EN, those outputs SHALL be tied to 0, clr SHALL be ignored, and no statistics registers exist; the compare pipeline is unchanged.

Structure
REQ-032 Package pair_eq_pkg SHALL hold the mode enum (MODE_XNOR, MODE_AND) and the function that computes first_err_ch width.
REQ-033 Sub-module pair_eq_lane SHALL implement one W-bit compare with stage-1 register and be instantiated CH times via generate.

Verification
REQ-034 Scenario 1: W=3, CH=2, XNOR; a={3'd5,3'd2}, b={3'd5,3'd2}, in_valid=1 -> 2 cycles later out_valid=1, eq_vec=2'b11, out=1, err_cnt=0.
REQ-035 Scenario 2: a={3'd5,3'd2}, b={3'd4,3'd2} -> eq_vec=2'b01, out=0, err_cnt=1, err_flag=1, first_err_ch=1; a further mismatch on pair 0 leaves first_err_ch=1.
REQ-036 Scenario 3: MODE_AND, both pairs unequal -> eq_vec=2'b00, out=0; under XNOR the same input gives out=1.
REQ-037 Scenario 4: CNT_W=2, 5 consecutive mismatches -> err_cnt stops at 3; clr coincident with the 5th event -> err_cnt=0, err_flag=0.
REQ-038 Scenario 5: rst asserted for one cycle while 2 results are in flight -> outputs zero immediately and no out_valid afterwards until new in_valid.
REQ-039 Scenario 6: 20000 random vectors with 1-bit probability 6/16 -> out matches a behavioural model every out_valid cycle; run with and without PAIR_EQ_CHECKER_STATS_EN.
